// File: rtl/flip_flop_fifo_with_levels.sv
// Show-ahead flip-flop FIFO with arbitrary depth, occupancy count and almost-full/empty levels.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERROR_FLAGS_EN.
module flip_flop_fifo_with_levels #(
    parameter int width                         = 8,
    parameter int depth                         = 5,
    parameter int almost_full_level             = 4,
    parameter int almost_empty_level            = 1,
    parameter bit allow_push_when_full_with_pop = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           write_data,
    output logic [width-1:0]           read_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = $clog2(depth + 1);
    localparam logic [ptr_w-1:0] last_ptr  = ptr_w'(depth - 1);
    localparam logic [cnt_w-1:0] depth_cnt = cnt_w'(depth);
    localparam logic [cnt_w-1:0] af_lvl    = cnt_w'(almost_full_level);
    localparam logic [cnt_w-1:0] ae_lvl    = cnt_w'(almost_empty_level);

    logic [width-1:0] mem_r [depth];
    logic [ptr_w-1:0] wr_ptr_r;
    logic [ptr_w-1:0] rd_ptr_r;
    logic [cnt_w-1:0] count_r;
    logic             push_acc_s;
    logic             pop_acc_s;
    logic             empty_s;
    logic             full_s;

    // Depth need not be a power of two, so wrap explicitly at the last slot.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        logic [ptr_w-1:0] n;
        if (p == last_ptr) begin
            n = {ptr_w{1'b0}};
        end else begin
            n = p + {{(ptr_w-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    // Handshake acceptance and status decode from the occupancy register.
    always_comb begin
        empty_s    = (count_r == {cnt_w{1'b0}});
        full_s     = (count_r == depth_cnt);
        pop_acc_s  = pop && !empty_s;
        if (allow_push_when_full_with_pop) begin
            push_acc_s = push && (!full_s || pop);
        end else begin
            push_acc_s = push && !full_s;
        end
    end

    assign read_data    = mem_r[rd_ptr_r];
    assign empty        = empty_s;
    assign full         = full_s;
    assign count        = count_r;
    assign almost_full  = (count_r >= af_lvl);
    assign almost_empty = (count_r <= ae_lvl);

    // Storage is intentionally left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_acc_s && !rst) begin
            mem_r[wr_ptr_r] <= write_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {ptr_w{1'b0}};
            rd_ptr_r <= {ptr_w{1'b0}};
            count_r  <= {cnt_w{1'b0}};
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_acc_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_r <= count_r + {{(cnt_w-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(cnt_w-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef FIFO_ERROR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; a push+pop while empty still counts as an underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push && !push_acc_s) begin
                overflow_r <= 1'b1;
            end
            if (pop && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_flip_flop_fifo_with_levels.sv
// Scoreboard bench: two FIFO instances (push-when-full-with-pop policy 1 and 0) driven with
// identical directed and random traffic, checked against queue-based reference models.
module tb_flip_flop_fifo_with_levels;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AFL   = 4;
    localparam int AEL   = 1;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          ovf;
        logic          unf;
    } st_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic          pop;
    logic [7:0]    wdata;
    logic [7:0]    rd [2];
    logic [CW-1:0] cn [2];
    logic          em [2];
    logic          fu [2];
    logic          af [2];
    logic          ae [2];
    logic          ov [2];
    logic          un [2];

    logic [7:0] mq  [2][$];
    logic [7:0] erd [2][$];
    st_t        est [2][$];
    bit         eov [2];
    bit         eun [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    flip_flop_fifo_with_levels #(
        .width(8), .depth(DEPTH), .almost_full_level(AFL), .almost_empty_level(AEL),
        .allow_push_when_full_with_pop(1'b0)
    ) u_pol0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .write_data(wdata),
        .read_data(rd[0]), .empty(em[0]), .full(fu[0]), .count(cn[0]),
        .almost_full(af[0]), .almost_empty(ae[0]), .overflow(ov[0]), .underflow(un[0])
    );

    flip_flop_fifo_with_levels #(
        .width(8), .depth(DEPTH), .almost_full_level(AFL), .almost_empty_level(AEL),
        .allow_push_when_full_with_pop(1'b1)
    ) u_pol1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .write_data(wdata),
        .read_data(rd[1]), .empty(em[1]), .full(fu[1]), .count(cn[1]),
        .almost_full(af[1]), .almost_empty(ae[1]), .overflow(ov[1]), .underflow(un[1])
    );

    task automatic chk(input string name, input int id, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[pol%0d] @%0t: got %0h expected %0h", name, id, $time, act, exp);
        end
    endtask

    // Reference model: records expected status for the current cycle, then applies the rules.
    task automatic model_step(input int id, input logic r, input logic pu, input logic po,
                              input logic [7:0] d);
        bit  pol;
        bit  emp;
        bit  ful;
        bit  pop_ok;
        bit  push_ok;
        st_t s;
        pol   = (id == 1);
        emp   = (mq[id].size() == 0);
        ful   = (mq[id].size() == DEPTH);
        s.cnt = CW'(mq[id].size());
        s.ovf = eov[id];
        s.unf = eun[id];
        est[id].push_back(s);
        if (r) begin
            mq[id].delete();
            eov[id] = 1'b0;
            eun[id] = 1'b0;
        end else begin
            pop_ok  = po && !emp;
            push_ok = pu && (!ful || (pol && po));
`ifdef FIFO_ERROR_FLAGS_EN
            if (pu && !push_ok) eov[id] = 1'b1;
            if (po && emp) eun[id] = 1'b1;
`endif
            if (pop_ok) erd[id].push_back(mq[id].pop_front());
            if (push_ok) mq[id].push_back(d);
        end
    endtask

    task automatic cyc(input logic r, input logic pu, input logic po, input logic [7:0] d);
        rst   = r;
        push  = pu;
        pop   = po;
        wdata = d;
        model_step(0, r, pu, po, d);
        model_step(1, r, pu, po, d);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares status each cycle and read data whenever a pop is presented to a non-empty DUT.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (est[i].size() > 0) begin
                st_t s;
                s = est[i].pop_front();
                chk("count", i, int'(cn[i]), int'(s.cnt));
                chk("empty", i, int'(em[i]), int'(s.cnt == 0));
                chk("full", i, int'(fu[i]), int'(s.cnt == DEPTH));
                chk("almost_full", i, int'(af[i]), int'(s.cnt >= AFL));
                chk("almost_empty", i, int'(ae[i]), int'(s.cnt <= AEL));
                chk("overflow", i, int'(ov[i]), int'(s.ovf));
                chk("underflow", i, int'(un[i]), int'(s.unf));
            end
            if (pop && !rst && !em[i]) begin
                if (erd[i].size() == 0) begin
                    chk("unexpected_pop_data", i, int'(rd[i]), -1);
                end else begin
                    logic [7:0] e;
                    e = erd[i].pop_front();
                    chk("read_data", i, int'(rd[i]), int'(e));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; wdata = 8'h00;
        @(posedge clk);
        #2;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        // Fill and drain
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 8'(k * 17));
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        // Wrap-around
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h60 + k));
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 8'(8'hA0 + k));
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        // Full with simultaneous push+pop
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 8'(k * 17));
        cyc(1'b0, 1'b1, 1'b1, 8'hAA);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        // Empty with push+pop
        cyc(1'b0, 1'b1, 1'b1, 8'h5A);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        // Overflow while full, then normal traffic, then reset
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h10 + k));
        cyc(1'b0, 1'b1, 1'b0, 8'hEE);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h21);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        // Reset mid-operation with push asserted
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h70 + k));
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        cyc(1'b0, 1'b1, 1'b0, 8'h3C);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        // Random traffic
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(63) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 60) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 50) ? 1'b1 : 1'b0,
                8'($urandom));
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("undrained_expected_data", i, erd[i].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
